img_transition_gen: RTL and testbench

//  Parametrised image-transition address generator for the VGA picture path. Sits between
//  vga_controller (h_cnt/v_cnt/valid) and the picture ROM. Maps each screen pixel to a
//  ROM address and a pixel-enable, animating SPLIT, WIPE or SCROLL transitions one step per tick.

---
 rtl/img_transition_gen.sv | 168 ++++++++++++++++
 tb/tb_img_transition_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/img_transition_gen.sv
// Image-transition address generator: maps VGA pixels to picture-ROM addresses and animates
// SPLIT/WIPE/SCROLL transitions. Define TRANS_MIRROR_EN to enable the vertical mirror input.
module img_transition_gen #(
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned STEP        = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned OFS_W       = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic [9:0]        h_cnt_i,
  input  logic [9:0]        v_cnt_i,
  input  logic              valid_i,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_mode_i,
  output logic              cmd_ready_o,
  input  logic              abort_i,
  input  logic              mirror_i,
  output logic [ADDR_W-1:0] pixel_addr_o,
  output logic              pix_en_o,
  output logic              busy_o,
  output logic              done_o
);

  // Common compare width: wide enough for coordinates, offsets and their sums.
  localparam int unsigned CW = ((OFS_W > 10) ? OFS_W : 10) + 2;

  localparam logic [1:0] ModeSplit  = 2'd0;
  localparam logic [1:0] ModeWipe   = 2'd1;
  localparam logic [1:0] ModeScroll = 2'd2;
  localparam logic [1:0] ModeRsvd   = 2'd3;

  typedef enum logic [1:0] {StIdle, StOut, StIn} state_e;

  state_e            state_q, state_d;
  logic [OFS_W-1:0]  offset_q, offset_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              pix_en_q, pix_en_d;

  logic [CW-1:0] ofs_ext, ofs_up;
  logic [CW-1:0] x, y_raw, y, xs;
  logic          in_img, blank;

  assign ofs_ext = CW'(offset_q);
  assign ofs_up  = ofs_ext + CW'(STEP);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && (cmd_mode_i != ModeRsvd)) begin
          mode_d  = cmd_mode_i;
          state_d = StOut;
        end
      end
      StOut: begin
        if (abort_i) begin
          offset_d = '0;
          state_d  = StIdle;
        end else if (tick_i) begin
          if (ofs_up >= CW'(IMG_W)) begin
            if (mode_q == ModeScroll) begin
              offset_d = '0;
              state_d  = StIdle;
              done_d   = 1'b1;
            end else begin
              offset_d = OFS_W'(IMG_W);
              state_d  = StIn;
            end
          end else begin
            offset_d = OFS_W'(ofs_up);
          end
        end
      end
      StIn: begin
        if (abort_i) begin
          offset_d = '0;
          state_d  = StIdle;
        end else if (tick_i) begin
          if (ofs_ext <= CW'(STEP)) begin
            offset_d = '0;
            state_d  = StIdle;
            done_d   = 1'b1;
          end else begin
            offset_d = offset_q - OFS_W'(STEP);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign x     = CW'(h_cnt_i >> SCALE_SHIFT);
  assign y_raw = CW'(v_cnt_i >> SCALE_SHIFT);

`ifdef TRANS_MIRROR_EN
  assign y = mirror_i ? (CW'(IMG_H - 1) - y_raw) : y_raw;
`else
  logic unused_mirror;
  assign unused_mirror = mirror_i;
  assign y = y_raw;
`endif

  assign in_img = valid_i && (x < CW'(IMG_W)) && (y_raw < CW'(IMG_H));

  always_comb begin
    xs    = x;
    blank = 1'b0;
    if (state_q != StIdle) begin
      unique case (mode_q)
        ModeSplit: begin
          if (y < CW'(IMG_H / 2)) begin
            xs    = x + ofs_ext;
            blank = (xs >= CW'(IMG_W));
          end else begin
            xs    = x - ofs_ext;
            blank = (x < ofs_ext);
          end
        end
        ModeWipe: blank = (x >= (CW'(IMG_W) - ofs_ext));
        ModeScroll: begin
          xs = x + ofs_ext;
          if (xs >= CW'(IMG_W)) xs = xs - CW'(IMG_W);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pixel_addr_d = pixel_addr_q;
    if (in_img) pixel_addr_d = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(xs);
    pix_en_d = in_img && !blank;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      offset_q     <= '0;
      mode_q       <= ModeSplit;
      done_q       <= 1'b0;
      pixel_addr_q <= '0;
      pix_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      mode_q       <= mode_d;
      done_q       <= done_d;
      pixel_addr_q <= pixel_addr_d;
      pix_en_q     <= pix_en_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q == StOut) || (state_q == StIn);
  assign done_o       = done_q;
  assign pixel_addr_o = pixel_addr_q;
  assign pix_en_o     = pix_en_q;

endmodule

// File: tb/tb_img_transition_gen.sv
// Bench for img_transition_gen (STEP=4): pixel vector tables through a scoreboard queue plus
// hand-written transition, abort and command-handling sequences.
module tb_img_transition_gen;

  logic        clk = 1'b0;
  logic        rst, tick, valid, cmd_valid, abort, mirror;
  logic [9:0]  h_cnt, v_cnt;
  logic [1:0]  cmd_mode;
  logic        cmd_ready, pix_en, busy, done;
  logic [16:0] pixel_addr;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int d0;

`ifdef TRANS_MIRROR_EN
  localparam int MirTop = 76480;
  localparam int MirMid = 74890;
`else
  localparam int MirTop = 0;
  localparam int MirMid = 1610;
`endif

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        valid;
    logic        mirror;
    logic        en;
    int          addr;
    logic        chk_addr;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];

  img_transition_gen #(
    .IMG_W(320), .IMG_H(240), .SCALE_SHIFT(1), .STEP(4), .ADDR_W(17), .OFS_W(10)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .h_cnt_i     (h_cnt),
    .v_cnt_i     (v_cnt),
    .valid_i     (valid),
    .cmd_valid_i (cmd_valid),
    .cmd_mode_i  (cmd_mode),
    .cmd_ready_o (cmd_ready),
    .abort_i     (abort),
    .mirror_i    (mirror),
    .pixel_addr_o(pixel_addr),
    .pix_en_o    (pix_en),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(string name, int act, int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, expv);
  endtask

  task automatic add(int h, int v, bit vld, bit mir, bit en, int addr, bit ca);
    vec_t e;
    e.h = 10'(h); e.v = 10'(v); e.valid = vld; e.mirror = mir;
    e.en = en; e.addr = addr; e.chk_addr = ca;
    tv.push_back(e);
  endtask

  task automatic run_vecs(string name);
    vec_t e;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      h_cnt = tv[i].h; v_cnt = tv[i].v; valid = tv[i].valid; mirror = tv[i].mirror;
      exp_q.push_back(tv[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d].pix_en", name, i), int'(pix_en), int'(e.en));
      if (e.chk_addr) chk($sformatf("%s[%0d].addr", name, i), int'(pixel_addr), e.addr);
      valid = 1'b0; mirror = 1'b0;
    end
    tv.delete();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic send_cmd(logic [1:0] m);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_mode = 2'd0;
  endtask

  task automatic do_abort(bit with_tick);
    @(negedge clk);
    abort = 1'b1; tick = with_tick;
    @(negedge clk);
    abort = 1'b0; tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 0; valid = 0; cmd_valid = 0; abort = 0; mirror = 0;
    h_cnt = 0; v_cnt = 0; cmd_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.cmd_ready", int'(cmd_ready), 1);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.pix_en", int'(pix_en), 0);
    chk("reset.addr", int'(pixel_addr), 0);

    // Idle identity mapping, out-of-range and hold behaviour.
    add(100, 50, 1, 0, 1, 8050, 1);
    add(700, 50, 0, 0, 0, 8050, 1);
    add(640, 0, 1, 0, 0, 8050, 1);
    add(0, 479, 1, 0, 1, 76480, 1);
    add(638, 0, 1, 0, 1, 319, 1);
    run_vecs("idle");

    // SPLIT: 80 ticks out, 80 in.
    d0 = done_cnt;
    send_cmd(2'd0);
    chk("split.busy", int'(busy), 1);
    chk("split.cmd_ready", int'(cmd_ready), 0);
    ticks(25);
    add(0, 0, 1, 0, 1, 100, 1);
    add(100, 300, 1, 0, 0, 0, 0);
    add(300, 0, 1, 0, 1, 250, 1);
    add(440, 0, 1, 0, 0, 320, 1);
    add(400, 300, 1, 0, 1, 48100, 1);
    run_vecs("split100");
    ticks(55);
    send_cmd(2'd2);  // must be ignored while busy
    add(0, 0, 1, 0, 0, 320, 1);
    run_vecs("split320");
    ticks(79);
    @(negedge clk);
    chk("split.busy_before_end", int'(busy), 1);
    chk("split.no_early_done", done_cnt - d0, 0);
    ticks(1);
    @(negedge clk);
    chk("split.done_count", done_cnt - d0, 1);
    chk("split.busy_after", int'(busy), 0);
    chk("split.cmd_ready_after", int'(cmd_ready), 1);

    // WIPE then abort during IN.
    d0 = done_cnt;
    send_cmd(2'd1);
    ticks(5);
    add(598, 0, 1, 0, 1, 299, 1);
    add(600, 0, 1, 0, 0, 300, 1);
    add(0, 0, 1, 0, 1, 0, 1);
    run_vecs("wipe20");
    ticks(75);
    add(0, 0, 1, 0, 0, 0, 1);
    add(200, 100, 1, 0, 0, 16100, 1);
    run_vecs("wipe320");
    do_abort(1'b1);
    chk("wipe_abort.busy", int'(busy), 0);
    @(negedge clk);
    chk("wipe_abort.no_done", done_cnt - d0, 0);

    // Abort with same-cycle tick during OUT; offset must return to 0.
    d0 = done_cnt;
    send_cmd(2'd0);
    ticks(3);
    do_abort(1'b1);
    chk("out_abort.busy", int'(busy), 0);
    chk("out_abort.cmd_ready", int'(cmd_ready), 1);
    send_cmd(2'd1);
    add(638, 0, 1, 0, 1, 319, 1);
    run_vecs("out_abort_ofs0");
    do_abort(1'b0);
    @(negedge clk);
    chk("out_abort.no_done", done_cnt - d0, 0);

    // SCROLL wraps and completes from OUT.
    d0 = done_cnt;
    send_cmd(2'd2);
    ticks(79);
    add(20, 0, 1, 0, 1, 6, 1);
    add(0, 0, 1, 0, 1, 316, 1);
    add(8, 2, 1, 0, 1, 320, 1);
    run_vecs("scroll316");
    chk("scroll.busy_before_end", int'(busy), 1);
    ticks(1);
    @(negedge clk);
    chk("scroll.done_count", done_cnt - d0, 1);
    chk("scroll.busy_after", int'(busy), 0);

    // Reserved mode is dropped.
    d0 = done_cnt;
    send_cmd(2'd3);
    chk("mode3.busy", int'(busy), 0);
    chk("mode3.cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    chk("mode3.no_done", done_cnt - d0, 0);

    // Mirror (effective only with TRANS_MIRROR_EN).
    add(0, 0, 1, 1, 1, MirTop, 1);
    add(0, 0, 1, 0, 1, 0, 1);
    add(20, 10, 1, 1, 1, MirMid, 1);
    run_vecs("mirror");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
